// File: rtl/mac_vec_feeder.sv
// mac_vec_feeder: buffers an N-pair vector, streams it into the MAC and returns the dot product
module mac_vec_feeder #(
    parameter int W    = 10,
    parameter int N    = 8,
    parameter int ACCW = 20
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [W-1:0]    s_a,
    input  logic [W-1:0]    s_b,
    output logic [W-1:0]    mac_a,
    output logic [W-1:0]    mac_b,
    output logic            mac_valid,
    output logic            mac_clr,
    input  logic [ACCW-1:0] mac_f,
    input  logic            mac_valid_out,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [ACCW-1:0] m_data,
    output logic            err
);
    localparam int CW = $clog2(N + 1);
    localparam int AW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    typedef enum logic [2:0] {LOAD, ISSUE, DRAIN, OUT, CLEAR} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, res_cnt_q, res_cnt_d;
    logic [W-1:0] mem_a_q [N];
    logic [W-1:0] mem_a_d [N];
    logic [W-1:0] mem_b_q [N];
    logic [W-1:0] mem_b_d [N];
    logic [W-1:0] mac_a_q, mac_a_d, mac_b_q, mac_b_d;
    logic [ACCW-1:0] m_data_q, m_data_d;
    logic s_ready_q, s_ready_d, mac_valid_q, mac_valid_d, mac_clr_q, mac_clr_d;
    logic m_valid_q, m_valid_d, err_q, err_d, done_q, done_d, busy;
    always_comb begin
        state_d = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        res_cnt_d = res_cnt_q;
        mem_a_d = mem_a_q;
        mem_b_d = mem_b_q;
        mac_a_d = mac_a_q;
        mac_b_d = mac_b_q;
        m_data_d = m_data_q;
        done_d = done_q;
        busy = (state_q == ISSUE) || (state_q == DRAIN);
        err_d = err_q || (mac_valid_out && !busy);
        // results may complete while issue is still running; done remembers that
        if (busy && !done_q && mac_valid_out) begin
            res_cnt_d = (res_cnt_q == LAST) ? '0 : res_cnt_q + CW'(1);
            m_data_d = (res_cnt_q == LAST) ? mac_f : m_data_q;
            done_d = (res_cnt_q == LAST);
        end
        case (state_q)
            LOAD: if (s_valid && s_ready_q) begin
                mem_a_d[wr_ptr_q[AW-1:0]] = s_a;
                mem_b_d[wr_ptr_q[AW-1:0]] = s_b;
                wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + CW'(1);
                state_d = (wr_ptr_q == LAST) ? ISSUE : LOAD;
            end
            ISSUE: begin
                mac_a_d = mem_a_q[rd_ptr_q[AW-1:0]];
                mac_b_d = mem_b_q[rd_ptr_q[AW-1:0]];
                rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + CW'(1);
                state_d = (rd_ptr_q != LAST) ? ISSUE : done_d ? OUT : DRAIN;
            end
            DRAIN: state_d = done_d ? OUT : DRAIN;
            OUT: begin
                done_d = 1'b0;
                state_d = (m_valid_q && m_ready) ? CLEAR : OUT;
            end
            CLEAR: state_d = LOAD;
            default: state_d = LOAD;
        endcase
        s_ready_d = (state_d == LOAD);
        mac_valid_d = (state_q == ISSUE);
        m_valid_d = (state_d == OUT);
        mac_clr_d = (state_d == CLEAR);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LOAD;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            res_cnt_q <= '0;
            mem_a_q <= '{default: '0};
            mem_b_q <= '{default: '0};
            mac_a_q <= '0;
            mac_b_q <= '0;
            m_data_q <= '0;
            s_ready_q <= 1'b0;
            mac_valid_q <= 1'b0;
            mac_clr_q <= 1'b0;
            m_valid_q <= 1'b0;
            err_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            res_cnt_q <= res_cnt_d;
            mem_a_q <= mem_a_d;
            mem_b_q <= mem_b_d;
            mac_a_q <= mac_a_d;
            mac_b_q <= mac_b_d;
            m_data_q <= m_data_d;
            s_ready_q <= s_ready_d;
            mac_valid_q <= mac_valid_d;
            mac_clr_q <= mac_clr_d;
            m_valid_q <= m_valid_d;
            err_q <= err_d;
            done_q <= done_d;
        end
    end
    assign s_ready = s_ready_q;
    assign mac_a = mac_a_q;
    assign mac_b = mac_b_q;
    assign mac_valid = mac_valid_q;
    assign mac_clr = mac_clr_q;
    assign m_valid = m_valid_q;
    assign m_data = m_data_q;
    assign err = err_q;
endmodule

// File: tb/tb_mac_vec_feeder.sv
// tb_mac_vec_feeder: drives vectors through the feeder against a saturating MAC model and checks dot products
module tb_mac_vec_feeder;
    localparam int W = 10;
    localparam int N = 8;
    localparam int ACCW = 20;
    localparam int MAXV = (1 << (ACCW - 1)) - 1;
    localparam int MINV = -(1 << (ACCW - 1));
    logic clk = 1'b0;
    logic reset, s_valid, s_ready, mac_valid, mac_clr, m_valid, m_ready, err;
    logic [W-1:0] s_a, s_b, mac_a, mac_b;
    logic [ACCW-1:0] mac_f = '0;
    logic [ACCW-1:0] m_data;
    logic mac_valid_out = 1'b0;
    int checks = 0;
    int failures = 0;
    int va [N];
    int vb [N];
    int lat = 1;
    bit inject = 1'b0;
    bit pv [4];
    int pp [4];
    int macc = 0;

    mac_vec_feeder #(.W(W), .N(N), .ACCW(ACCW)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_valid(mac_valid), .mac_clr(mac_clr),
        .mac_f(mac_f), .mac_valid_out(mac_valid_out), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .err(err)
    );

    always #5 clk = ~clk;

    function automatic int clamp(input int v);
        return (v > MAXV) ? MAXV : (v < MINV) ? MINV : v;
    endfunction

    function automatic logic [ACCW-1:0] dot();
        int s = 0;
        for (int i = 0; i < N; i++) s = clamp(s + va[i] * vb[i]);
        return ACCW'(s);
    endfunction

    // Saturating MAC with configurable latency, updated on the falling edge
    always @(negedge clk) begin
        bit o;
        int p;
        if (!reset || mac_clr) begin
            for (int i = 0; i < 4; i++) begin
                pv[i] = 1'b0;
                pp[i] = 0;
            end
            macc = 0;
            mac_valid_out = 1'b0;
            mac_f = '0;
        end else begin
            o = pv[lat-1];
            p = pp[lat-1];
            for (int i = 3; i > 0; i--) begin
                pv[i] = pv[i-1];
                pp[i] = pp[i-1];
            end
            pv[0] = mac_valid;
            pp[0] = int'($signed(mac_a)) * int'($signed(mac_b));
            if (o) macc = clamp(macc + p);
            mac_valid_out = o | inject;
            inject = 1'b0;
            mac_f = ACCW'(macc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_vec();
        for (int i = 0; i < N; i++) begin
            va[i] = int'($urandom_range(0, 1023)) - 512;
            vb[i] = int'($urandom_range(0, 1023)) - 512;
        end
    endtask

    task automatic load_vec(input bit gaps);
        int i = 0;
        int guard = 0;
        bit acc_now;
        while (i < N && guard < 200) begin
            s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            s_a = s_valid ? va[i][W-1:0] : W'($urandom);
            s_b = s_valid ? vb[i][W-1:0] : W'($urandom);
            acc_now = s_valid && s_ready;
            @(posedge clk); #1;
            guard++;
            if (acc_now) i++;
        end
        s_valid = 1'b0;
        chk("load_accepted", i, N);
    endtask

    task automatic run_vec(input logic [ACCW-1:0] exp, input int hold, input bit gaps, input bit junk);
        int mv = 0;
        int first = -1;
        int last = -1;
        int cyc = 0;
        int clr = 0;
        bit data_ok = 1'b1;
        bit ready_low = 1'b1;
        bit stable = 1'b1;
        logic [ACCW-1:0] held;
        load_vec(gaps);
        m_ready = (hold == 0);
        while (!m_valid && cyc < 200) begin
            if (junk) begin
                s_valid = 1'b1;
                s_a = W'($urandom);
                s_b = W'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
            if (s_ready) ready_low = 1'b0;
            if (mac_clr) clr++;
            if (mac_valid) begin
                if (mv >= N || mac_a !== va[mv][W-1:0] || mac_b !== vb[mv][W-1:0]) data_ok = 1'b0;
                if (first < 0) first = cyc;
                last = cyc;
                mv++;
            end
        end
        s_valid = 1'b0;
        chk("s_ready_low_busy", 32'(ready_low), 1);
        chk("mac_valid_count", mv, N);
        chk("mac_valid_back_to_back", last - first + 1, N);
        chk("mac_operands", 32'(data_ok), 1);
        chk("m_valid_rise", 32'(m_valid), 1);
        chk("m_data", 32'(m_data), 32'(exp));
        held = m_data;
        repeat (hold) begin
            @(posedge clk); #1;
            if (!m_valid || m_data !== held) stable = 1'b0;
            if (mac_clr) clr++;
        end
        if (hold > 0) begin
            chk("out_hold_stable", 32'(stable), 1);
            m_ready = 1'b1;
        end
        @(posedge clk); #1;
        if (mac_clr) clr++;
        chk("handshake_drop", 32'({m_valid, mac_clr}), 1);
        @(posedge clk); #1;
        if (mac_clr) clr++;
        chk("clr_pulses", clr, 1);
        chk("s_ready_after_clr", 32'(s_ready), 1);
        m_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        s_valid = 1'b0;
        s_a = '0;
        s_b = '0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl_outputs", 32'({s_ready, mac_valid, mac_clr, m_valid, err}), 0);
        chk("rst_mac_ab", 32'({mac_a, mac_b}), 0);
        chk("rst_m_data", 32'(m_data), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("s_ready_after_reset", 32'(s_ready), 1);
        for (int i = 0; i < N; i++) begin
            va[i] = i + 1;
            vb[i] = 2;
        end
        run_vec(20'd72, 0, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) begin
            va[i] = 511;
            vb[i] = 511;
        end
        run_vec(20'h7FFFF, 0, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) va[i] = -512;
        run_vec(20'h80000, 0, 1'b0, 1'b0);
        lat = 3;
        rand_vec();
        run_vec(dot(), 20, 1'b0, 1'b0);
        rand_vec();
        run_vec(dot(), 0, 1'b1, 1'b0);
        rand_vec();
        run_vec(dot(), 1, 1'b0, 1'b1);
        rand_vec();
        run_vec(dot(), 0, 1'b0, 1'b0);
        rand_vec();
        load_vec(1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("issue_active_before_reset", 32'(mac_valid), 1);
        reset = 1'b0;
        #1;
        chk("midreset_ctrl", 32'({s_ready, mac_valid, mac_clr, m_valid, err}), 0);
        chk("midreset_mac_ab", 32'({mac_a, mac_b}), 0);
        chk("midreset_m_data", 32'(m_data), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        rand_vec();
        run_vec(dot(), 0, 1'b0, 1'b0);
        chk("err_clear_after_reset", 32'(err), 0);
        inject = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("err_set_in_load", 32'(err), 1);
        rand_vec();
        run_vec(dot(), 0, 1'b1, 1'b0);
        chk("err_sticky", 32'(err), 1);
        for (int k = 0; k < 8; k++) begin
            lat = int'($urandom_range(1, 4));
            rand_vec();
            run_vec(dot(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        chk("err_sticky_end", 32'(err), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
